alu_branch_unit: RTL and testbench

ALU_BRANCH_UNIT -- requirements
Module: alu_branch_unit

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_core.sv | 38 +++
 rtl/alu_branch_unit.sv | 84 ++++++++
 tb/tb_alu_branch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU / branch unit.
// Shifter support is gated by ALU_SHIFT_EN (see alu_core).
package alu_pkg;

  typedef logic [31:0] data_t;

  typedef enum logic [2:0] {
    ALUOP_ADD    = 3'b000,
    ALUOP_BRANCH = 3'b001,
    ALUOP_RTYPE  = 3'b010,
    ALUOP_ITYPE  = 3'b011,
    ALUOP_PASS   = 3'b100
  } aluop_e;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_PASS = 4'b1010
  } alu_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Shared R/I-type funct3 decode; sub_ok is cleared for I-type so ADDI never becomes SUB.
  function automatic alu_op_e funct3_op(input logic [2:0] f3, input logic alt, input logic sub_ok);
    alu_op_e op;
    case (f3)
      3'b000:  op = (alt && sub_ok) ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = alt ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU datapath.
// Shifts exist only when ALU_SHIFT_EN is defined; otherwise shift codes yield 0.
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]  i_Op,
  input  logic [31:0] i_Op1,
  input  logic [31:0] i_Op2,
  output logic [31:0] o_Result,
  output logic        o_Zero
);

  logic [4:0] w_shamt;
  assign w_shamt = i_Op2[4:0];

  always_comb begin
    o_Result = '0;
    case (i_Op)
      OP_AND:  o_Result = i_Op1 & i_Op2;
      OP_OR:   o_Result = i_Op1 | i_Op2;
      OP_ADD:  o_Result = i_Op1 + i_Op2;
      OP_XOR:  o_Result = i_Op1 ^ i_Op2;
      OP_SUB:  o_Result = i_Op1 - i_Op2;
      OP_SLT:  o_Result = {31'd0, ($signed(i_Op1) < $signed(i_Op2))};
      OP_SLTU: o_Result = {31'd0, (i_Op1 < i_Op2)};
      OP_PASS: o_Result = i_Op2;
`ifdef ALU_SHIFT_EN
      OP_SLL:  o_Result = i_Op1 << w_shamt;
      OP_SRL:  o_Result = i_Op1 >> w_shamt;
      OP_SRA:  o_Result = data_t'($signed(i_Op1) >>> w_shamt);
`endif
      default: o_Result = '0;
    endcase
  end

  assign o_Zero = (o_Result == '0);

endmodule

// File: rtl/alu_branch_unit.sv
// ALU control decode, branch/jump resolution and one-cycle output registers.
// Shift operations depend on ALU_SHIFT_EN in alu_core.
module alu_branch_unit
  import alu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_Valid,
  input  logic [2:0]  i_ALUOp,
  input  logic [2:0]  i_Funct3,
  input  logic [6:0]  i_Funct7,
  input  logic [31:0] i_Op1,
  input  logic [31:0] i_Op2,
  input  logic        i_Branch,
  input  logic        i_Jump,
  output logic        o_Valid,
  output logic [31:0] o_Result,
  output logic        o_Zero,
  output logic        o_B_J_result
);

  logic [3:0] w_op;
  data_t      w_result;
  logic       w_zero;
  logic       w_cond;
  logic       w_taken;
  logic       w_unused_funct7;

  // Only funct7[5] distinguishes SUB/SRA; the remaining bits are don't-care.
  assign w_unused_funct7 = ^{i_Funct7[6], i_Funct7[4:0]};

  always_comb begin
    w_op = OP_ADD;
    case (i_ALUOp)
      ALUOP_BRANCH: begin
        case (i_Funct3)
          F3_BLT, F3_BGE:   w_op = OP_SLT;
          F3_BLTU, F3_BGEU: w_op = OP_SLTU;
          default:          w_op = OP_SUB;
        endcase
      end
      ALUOP_RTYPE: w_op = funct3_op(i_Funct3, i_Funct7[5], 1'b1);
      ALUOP_ITYPE: w_op = funct3_op(i_Funct3, i_Funct7[5], 1'b0);
      ALUOP_PASS:  w_op = OP_PASS;
      default:     w_op = OP_ADD;
    endcase
  end

  alu_core u_alu_core (
    .i_Op     (w_op),
    .i_Op1    (i_Op1),
    .i_Op2    (i_Op2),
    .o_Result (w_result),
    .o_Zero   (w_zero)
  );

  always_comb begin
    w_cond = 1'b0;
    case (i_Funct3)
      F3_BEQ, F3_BGE, F3_BGEU: w_cond = w_zero;
      F3_BNE, F3_BLT, F3_BLTU: w_cond = !w_zero;
      default:                 w_cond = 1'b0;
    endcase
  end

  assign w_taken = i_Jump | (i_Branch & w_cond);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_Valid      <= 1'b0;
      o_Result     <= '0;
      o_Zero       <= 1'b0;
      o_B_J_result <= 1'b0;
    end else begin
      o_Valid <= i_Valid;
      if (i_Valid) begin
        o_Result     <= w_result;
        o_Zero       <= w_zero;
        o_B_J_result <= w_taken;
      end
    end
  end

endmodule

// File: tb/tb_alu_branch_unit.sv
// Self-checking bench for alu_branch_unit: directed cases plus randomized traffic vs a reference model.
// Expected shift results follow ALU_SHIFT_EN as compiled.
module tb_alu_branch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_Valid = 1'b0;
  logic [2:0]  i_ALUOp = '0;
  logic [2:0]  i_Funct3 = '0;
  logic [6:0]  i_Funct7 = '0;
  logic [31:0] i_Op1 = '0;
  logic [31:0] i_Op2 = '0;
  logic        i_Branch = 1'b0;
  logic        i_Jump = 1'b0;
  logic        o_Valid;
  logic [31:0] o_Result;
  logic        o_Zero;
  logic        o_B_J_result;

`ifdef ALU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic        exp_v = 1'b0;
  logic [31:0] exp_r = '0;
  logic        exp_z = 1'b0;
  logic        exp_t = 1'b0;

  alu_branch_unit dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_Valid      (i_Valid),
    .i_ALUOp      (i_ALUOp),
    .i_Funct3     (i_Funct3),
    .i_Funct7     (i_Funct7),
    .i_Op1        (i_Op1),
    .i_Op2        (i_Op2),
    .i_Branch     (i_Branch),
    .i_Jump       (i_Jump),
    .o_Valid      (o_Valid),
    .o_Result     (o_Result),
    .o_Zero       (o_Zero),
    .o_B_J_result (o_B_J_result)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] slt(input logic [31:0] a, input logic [31:0] b, input bit signed_cmp);
    if (signed_cmp) return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    return (a < b) ? 32'd1 : 32'd0;
  endfunction

  // Arithmetic right shift written as complement / logical shift / complement.
  function automatic logic [31:0] sra(input logic [31:0] a, input int sh);
    if (a[31]) return ~((~a) >> sh);
    return a >> sh;
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] aop, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] a,
                                             input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if (aop == 3'd4) return b;
    if (aop == 3'd1) begin
      if (f3 == 3'd4 || f3 == 3'd5) return slt(a, b, 1'b1);
      if (f3 == 3'd6 || f3 == 3'd7) return slt(a, b, 1'b0);
      return a - b;
    end
    if (aop == 3'd2 || aop == 3'd3) begin
      case (f3)
        3'd0: return (aop == 3'd2 && f7[5]) ? a - b : a + b;
        3'd1: return SHIFT_EN ? a << sh : 32'd0;
        3'd2: return slt(a, b, 1'b1);
        3'd3: return slt(a, b, 1'b0);
        3'd4: return a ^ b;
        3'd5: return SHIFT_EN ? (f7[5] ? sra(a, sh) : a >> sh) : 32'd0;
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    return a + b;
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] res,
                                     input logic br, input logic jmp);
    if (jmp) return 1'b1;
    if (!br) return 1'b0;
    case (f3)
      3'd0, 3'd5, 3'd7: return res == 32'd0;
      3'd1, 3'd4, 3'd6: return res != 32'd0;
      default:          return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, updating the expected register image first.
  task automatic step();
    logic [31:0] r;
    if (i_rst) begin
      exp_v = 1'b0; exp_r = '0; exp_z = 1'b0; exp_t = 1'b0;
    end else begin
      exp_v = i_Valid;
      if (i_Valid) begin
        r = ref_result(i_ALUOp, i_Funct3, i_Funct7, i_Op1, i_Op2);
        exp_r = r;
        exp_z = (r == 32'd0);
        exp_t = ref_taken(i_Funct3, r, i_Branch, i_Jump);
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'd0, o_Valid}, {31'd0, exp_v});
    chk({tag, ".result"}, o_Result, exp_r);
    chk({tag, ".zero"}, {31'd0, o_Zero}, {31'd0, exp_z});
    chk({tag, ".taken"}, {31'd0, o_B_J_result}, {31'd0, exp_t});
  endtask

  task automatic apply(input string tag, input logic [2:0] aop, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic br, input logic jmp);
    i_Valid = 1'b1; i_ALUOp = aop; i_Funct3 = f3; i_Funct7 = f7;
    i_Op1 = a; i_Op2 = b; i_Branch = br; i_Jump = jmp;
    step();
    check_all(tag);
  endtask

  initial begin
    // Reset coincident with valid data: reset must win.
    i_rst = 1'b1; i_Valid = 1'b1; i_ALUOp = 3'd0; i_Op1 = 32'd3; i_Op2 = 32'd4; i_Jump = 1'b1;
    step();
    chk("rst.valid", {31'd0, o_Valid}, 32'd0);
    chk("rst.result", o_Result, 32'd0);
    chk("rst.zero", {31'd0, o_Zero}, 32'd0);
    chk("rst.taken", {31'd0, o_B_J_result}, 32'd0);
    i_rst = 1'b0; i_Valid = 1'b0; i_Jump = 1'b0;
    step();
    step();
    chk("idle.result", o_Result, 32'd0);
    chk("idle.zero", {31'd0, o_Zero}, 32'd0);
    chk("idle.taken", {31'd0, o_B_J_result}, 32'd0);
    check_all("idle");

    apply("sub", 3'd2, 3'd0, 7'b0100000, 32'd5, 32'd7, 1'b0, 1'b0);
    chk("sub.literal", o_Result, 32'hFFFFFFFE);
    apply("blt", 3'd1, 3'd4, 7'd0, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
    chk("blt.literal", {o_Result[30:0], o_B_J_result}, {31'd1, 1'b1});
    apply("bltu", 3'd1, 3'd6, 7'd0, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
    chk("bltu.literal", {o_Result[30:0], o_B_J_result}, {31'd0, 1'b0});
    apply("beq", 3'd1, 3'd0, 7'd0, 32'h1234, 32'h1234, 1'b1, 1'b0);
    chk("beq.literal", {30'd0, o_Zero, o_B_J_result}, 32'd3);
    apply("bne", 3'd1, 3'd1, 7'd0, 32'h1234, 32'h1234, 1'b1, 1'b0);
    chk("bne.literal", {31'd0, o_B_J_result}, 32'd0);
    apply("srai", 3'd3, 3'd5, 7'b0100000, 32'h80000000, 32'd4, 1'b0, 1'b0);
    chk("srai.literal", o_Result, SHIFT_EN ? 32'hF8000000 : 32'd0);
    apply("jump", 3'd0, 3'd0, 7'd0, 32'd10, 32'd20, 1'b0, 1'b1);
    chk("jump.literal", {31'd0, o_B_J_result}, 32'd1);
    apply("addi_f7", 3'd3, 3'd0, 7'b0100000, 32'd5, 32'd7, 1'b0, 1'b0);
    apply("lui", 3'd4, 3'd3, 7'd0, 32'hDEAD0000, 32'h12345000, 1'b0, 1'b0);
    apply("aluop7", 3'd7, 3'd2, 7'd0, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    apply("br010", 3'd1, 3'd2, 7'd0, 32'd9, 32'd9, 1'b1, 1'b0);
    apply("br_jmp", 3'd1, 3'd1, 7'd0, 32'd9, 32'd9, 1'b1, 1'b1);

    // Hold check: drop valid, outputs keep last values while o_Valid falls.
    i_Valid = 1'b0; i_Op1 = 32'h55; i_Jump = 1'b0;
    step();
    check_all("hold");

    for (int i = 0; i < 400; i++) begin
      i_rst    = ($urandom_range(0, 39) == 0);
      i_Valid  = ($urandom_range(0, 3) != 0);
      i_ALUOp  = 3'($urandom_range(0, 7));
      i_Funct3 = 3'($urandom_range(0, 7));
      i_Funct7 = 7'($urandom);
      i_Op1    = $urandom;
      case ($urandom_range(0, 3))
        0:       i_Op2 = i_Op1;
        1:       i_Op2 = 32'($urandom_range(0, 40));
        default: i_Op2 = $urandom;
      endcase
      i_Branch = ($urandom_range(0, 1) == 1);
      i_Jump   = ($urandom_range(0, 5) == 0);
      step();
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
